// File: rtl/zhegalkin_pkg.sv
// Shared types and constants for the Zhegalkin sweep controller.
// The optional transform is enabled by defining ANF_TRANSFORM_EN.
package zhegalkin_pkg;

  localparam int DEF_N_VARS = 4;
  localparam int STG_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    XFORM,
    DONE
  } state_e;

  function automatic int tt_w(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/zhegalkin_sweep_ctrl_anf_butterfly_stage.sv
// One Mobius butterfly stage: c[i] ^= c[i ^ (1<<s)] where bit s of i is set.
// Present only when ANF_TRANSFORM_EN is defined.
`ifdef ANF_TRANSFORM_EN
module anf_butterfly_stage
  import zhegalkin_pkg::*;
#(
  parameter int N_VARS = DEF_N_VARS,
  localparam int TT_W = tt_w(N_VARS)
) (
  input  logic [TT_W-1:0]  vec_i,
  input  logic [STG_W-1:0] stage_i,
  output logic [TT_W-1:0]  vec_o
);

  always_comb begin
    vec_o = vec_i;
    for (int i = 0; i < TT_W; i++) begin
      if (((i >> stage_i) & 1) == 1) begin
        vec_o[i] = vec_i[i] ^ vec_i[i ^ (1 << stage_i)];
      end
    end
  end

endmodule
`endif

// File: rtl/zhegalkin_sweep_ctrl.sv
// Exhaustive input sweep + truth-table capture for an ANF evaluator.
// Define ANF_TRANSFORM_EN to add the in-place Mobius transform to anf_coef.
module zhegalkin_sweep_ctrl
  import zhegalkin_pkg::*;
#(
  parameter int N_VARS = DEF_N_VARS,
  localparam int TT_W = tt_w(N_VARS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [N_VARS-1:0] x_out,
  input  logic              z_in,
  output logic              busy,
  output logic              done,
`ifdef ANF_TRANSFORM_EN
  output logic [TT_W-1:0]   anf_coef,
`endif
  output logic [TT_W-1:0]   truth_tbl
);

  state_e state_q, state_d;
  logic [N_VARS-1:0] cnt_q, cnt_d;
  logic [TT_W-1:0] tt_q, tt_d;
  logic last_smp;

  assign last_smp = &cnt_q;

`ifdef ANF_TRANSFORM_EN
  logic [STG_W-1:0] stg_q, stg_d;
  logic [TT_W-1:0] coef_q, coef_d, bfly;
  logic last_stg;

  assign last_stg = (stg_q == STG_W'(N_VARS - 1));

  anf_butterfly_stage #(
    .N_VARS (N_VARS)
  ) u_bfly (
    .vec_i   (coef_q),
    .stage_i (stg_q),
    .vec_o   (bfly)
  );
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start) state_d = SWEEP;
      SWEEP: begin
        if (last_smp) begin
`ifdef ANF_TRANSFORM_EN
          state_d = XFORM;
`else
          state_d = DONE;
`endif
        end
      end
      XFORM: begin
`ifdef ANF_TRANSFORM_EN
        if (last_stg) state_d = DONE;
`else
        state_d = IDLE;
`endif
      end
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == SWEEP) || (state_q == XFORM);
    done = (state_q == DONE);
  end

  // The counter wraps to 0 after the last sample, so x_out idles at 0.
  always_comb begin
    cnt_d = cnt_q;
    tt_d  = tt_q;
    if (state_q == IDLE && start) begin
      cnt_d = '0;
      tt_d  = '0;
    end else if (state_q == SWEEP) begin
      tt_d[cnt_q] = z_in;
      cnt_d       = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      tt_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      tt_q  <= tt_d;
    end
  end

  assign x_out     = cnt_q;
  assign truth_tbl = tt_q;

`ifdef ANF_TRANSFORM_EN
  always_comb begin
    stg_d  = stg_q;
    coef_d = coef_q;
    if (state_q == IDLE && start) begin
      stg_d  = '0;
      coef_d = '0;
    end else if (state_q == SWEEP && last_smp) begin
      coef_d = tt_d;
    end else if (state_q == XFORM) begin
      coef_d = bfly;
      stg_d  = stg_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_q  <= '0;
      coef_q <= '0;
    end else begin
      stg_q  <= stg_d;
      coef_q <= coef_d;
    end
  end

  assign anf_coef = coef_q;
`endif

endmodule
